hilo_muldiv_unit: RTL

- Execute-stage responder for the HI/LO instruction class emitted by the decode control: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- Owns the architectural HI/LO registers and runs multi-cycle multiply and iterative divide.
- Raises a stall to the pipeline only while a HI/LO-touching instruction collides with an operation still in flight.

---
 rtl/hilo_pkg.sv | 34 +++
 rtl/div_iter_core.sv | 67 ++++++
 rtl/hilo_muldiv_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: state encoding,
// the ALU operation codes of the HI/LO class, and divider constants.
package hilo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL      = 2'd1,
    ST_DIV_LOOP = 2'd2,
    ST_DIV_FIX  = 2'd3
  } hilo_state_e;

  // ALU operation codes produced by the decode control
  localparam logic [5:0] ALU_ADD   = 6'h20;
  localparam logic [5:0] ALU_MFHI  = 6'h10;
  localparam logic [5:0] ALU_MTHI  = 6'h11;
  localparam logic [5:0] ALU_MFLO  = 6'h12;
  localparam logic [5:0] ALU_MTLO  = 6'h13;
  localparam logic [5:0] ALU_MULT  = 6'h18;
  localparam logic [5:0] ALU_MULTU = 6'h19;
  localparam logic [5:0] ALU_DIV   = 6'h1A;
  localparam logic [5:0] ALU_DIVU  = 6'h1B;

  // One quotient bit per iteration
  localparam int DIV_ITERS = 32;

  // True for every operation that reads or writes HI/LO
  function automatic logic is_hilo_op(input logic [5:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) ||
           (op == ALU_DIV)  || (op == ALU_DIVU)  ||
           (op == ALU_MTHI) || (op == ALU_MTLO)  ||
           (op == ALU_MFHI) || (op == ALU_MFLO);
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Serial restoring radix-2 divider on unsigned 32-bit operands.
// start loads the operands; the core then produces one quotient bit per
// cycle for DIV_ITERS cycles. last is high in the cycle performing the
// final iteration, so quotient/remainder are final from the next cycle.
module div_iter_core
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        run_reg;
  logic [5:0]  cnt_reg;
  logic [31:0] rem_reg;
  logic [31:0] quot_reg;
  logic [31:0] dvsr_reg;

  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic        fits;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    rem_shift = {rem_reg, quot_reg[31]};
    diff      = rem_shift - {1'b0, dvsr_reg};
    fits      = ~diff[32];
  end

  assign last      = run_reg && (cnt_reg == 6'(DIV_ITERS - 1));
  assign quotient  = quot_reg;
  assign remainder = rem_reg;

  // Iteration state: load on start, shift one bit per cycle while running
  always_ff @(posedge clk) begin
    if (rst) begin
      run_reg  <= 1'b0;
      cnt_reg  <= 6'd0;
      rem_reg  <= 32'd0;
      quot_reg <= 32'd0;
      dvsr_reg <= 32'd0;
    end else if (abort) begin
      run_reg <= 1'b0;
      cnt_reg <= 6'd0;
    end else if (start) begin
      run_reg  <= 1'b1;
      cnt_reg  <= 6'd0;
      rem_reg  <= 32'd0;
      quot_reg <= dividend;
      dvsr_reg <= divisor;
    end else if (run_reg) begin
      rem_reg  <= fits ? diff[31:0] : rem_shift[31:0];
      quot_reg <= {quot_reg[30:0], fits};
      cnt_reg  <= cnt_reg + 6'd1;
      if (last) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Execute-stage HI/LO unit: owns HI/LO, runs the multi-cycle multiply and
// the iterative divide, and stalls HI/LO instructions while busy.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int MULT_CYCLES = 2
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        valid,
  input  logic [5:0]  alu_op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        stall,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  hilo_state_e state_reg, state_next;
  logic        busy_reg;

  logic [31:0] hi_reg, lo_reg;
  logic        done_reg;

  logic [31:0] mul_a_reg, mul_b_reg;
  logic        mul_signed_reg;
  logic [3:0]  mul_cnt_reg;

  logic        div_signed_reg;
  logic        sign_a_reg, sign_b_reg;
  logic        div_zero_reg;
  logic [31:0] div_a_raw_reg;

  logic        hilo_op, accept;
  logic        op_mul, op_div, op_signed;
  logic        mul_last;
  logic [63:0] mul_a_ext, mul_b_ext, product;
  logic [31:0] div_dividend, div_divisor;
  logic        div_last;
  logic [31:0] div_quot, div_rem;

  logic        mul_load, div_start;
  logic        hi_we, lo_we, done_next;
  logic [31:0] hi_wdata, lo_wdata;

  assign hilo_op   = is_hilo_op(alu_op);
  assign stall     = busy_reg & valid & hilo_op;
  assign accept    = valid & hilo_op & ~stall & ~flush;
  assign op_mul    = (alu_op == ALU_MULT) || (alu_op == ALU_MULTU);
  assign op_div    = (alu_op == ALU_DIV)  || (alu_op == ALU_DIVU);
  assign op_signed = (alu_op == ALU_MULT) || (alu_op == ALU_DIV);
  assign mul_last  = (state_reg == ST_MUL) && (mul_cnt_reg == 4'(MULT_CYCLES));

  // Extending to 64 bits makes the low 64 product bits right for both signednesses
  assign mul_a_ext = {{32{mul_signed_reg & mul_a_reg[31]}}, mul_a_reg};
  assign mul_b_ext = {{32{mul_signed_reg & mul_b_reg[31]}}, mul_b_reg};
  assign product   = mul_a_ext * mul_b_ext;

  // Signed divides run on magnitudes; signs are re-applied in DIV_FIX
  assign div_dividend = (alu_op == ALU_DIV && operand_a[31]) ? (~operand_a + 32'd1) : operand_a;
  assign div_divisor  = (alu_op == ALU_DIV && operand_b[31]) ? (~operand_b + 32'd1) : operand_b;

  div_iter_core u_div (
    .clk       (clk),
    .rst       (rst),
    .abort     (flush),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .last      (div_last),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  // State register; busy is registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept && op_mul) state_next = ST_MUL;
          else if (accept && op_div) state_next = ST_DIV_LOOP;
        end
        ST_MUL:      if (mul_last) state_next = ST_IDLE;
        ST_DIV_LOOP: if (div_last) state_next = ST_DIV_FIX;
        ST_DIV_FIX:  state_next = ST_IDLE;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode: operand loads, HI/LO write enables and data, done
  always_comb begin
    mul_load  = 1'b0;
    div_start = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_wdata  = operand_a;
    lo_wdata  = operand_a;
    done_next = 1'b0;
    if (state_reg == ST_IDLE && accept) begin
      mul_load  = op_mul;
      div_start = op_div;
      hi_we     = (alu_op == ALU_MTHI);
      lo_we     = (alu_op == ALU_MTLO);
    end
    if (mul_last && !flush) begin
      hi_we     = 1'b1;
      lo_we     = 1'b1;
      hi_wdata  = product[63:32];
      lo_wdata  = product[31:0];
      done_next = 1'b1;
    end
    if (state_reg == ST_DIV_FIX && !flush) begin
      hi_we     = 1'b1;
      lo_we     = 1'b1;
      done_next = 1'b1;
      if (div_zero_reg) begin
        hi_wdata = div_a_raw_reg;
        lo_wdata = 32'hFFFF_FFFF;
      end else begin
        hi_wdata = (div_signed_reg && sign_a_reg) ? (~div_rem + 32'd1) : div_rem;
        lo_wdata = (div_signed_reg && (sign_a_reg ^ sign_b_reg)) ? (~div_quot + 32'd1) : div_quot;
      end
    end
  end

  // Architectural HI/LO, done pulse and latched operation context
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg         <= 32'd0;
      lo_reg         <= 32'd0;
      done_reg       <= 1'b0;
      mul_a_reg      <= 32'd0;
      mul_b_reg      <= 32'd0;
      mul_signed_reg <= 1'b0;
      mul_cnt_reg    <= 4'd0;
      div_signed_reg <= 1'b0;
      sign_a_reg     <= 1'b0;
      sign_b_reg     <= 1'b0;
      div_zero_reg   <= 1'b0;
      div_a_raw_reg  <= 32'd0;
    end else begin
      done_reg <= done_next;
      if (hi_we) hi_reg <= hi_wdata;
      if (lo_we) lo_reg <= lo_wdata;
      if (mul_load) begin
        mul_a_reg      <= operand_a;
        mul_b_reg      <= operand_b;
        mul_signed_reg <= op_signed;
        mul_cnt_reg    <= 4'd1;
      end else if (state_reg == ST_MUL) begin
        mul_cnt_reg <= mul_cnt_reg + 4'd1;
      end
      if (div_start) begin
        div_signed_reg <= op_signed;
        sign_a_reg     <= op_signed & operand_a[31];
        sign_b_reg     <= op_signed & operand_b[31];
        div_zero_reg   <= (operand_b == 32'd0);
        div_a_raw_reg  <= operand_a;
      end
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign hi      = hi_reg;
  assign lo      = lo_reg;
  assign rd_data = (alu_op == ALU_MFHI) ? hi_reg : lo_reg;

endmodule
